// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder that streams operands through a 4-bit carry-look-ahead slice,
// one nibble per clock, LSB nibble first, behind valid/ready handshakes on both sides.

module carry_look_ahead_adder (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       cout_o
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  always_comb begin
    g    = a_i & b_i;
    p    = a_i ^ b_i;
    c[0] = cin_i;
    c[1] = g[0] | (p[0] & cin_i);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin_i);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin_i);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]) |
           (p[3] & p[2] & p[1] & p[0] & cin_i);
    sum_o  = p ^ c[3:0];
    cout_o = c[4];
  end

endmodule

module nibble_serial_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             busy
);

  if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4");
  end

  localparam int unsigned Nib  = WIDTH / 4;
  localparam int unsigned IdxW = (Nib > 1) ? $clog2(Nib) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(Nib - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StAdd  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [IdxW+1:0]  bit_off;
  logic [3:0]       nib_a;
  logic [3:0]       nib_b;
  logic [3:0]       nib_sum;
  logic             nib_cout;
  logic             msb_cin;

  always_comb begin
    bit_off = {idx_q, 2'b00};
    nib_a   = a_q[bit_off +: 4];
    nib_b   = b_q[bit_off +: 4];
  end

  carry_look_ahead_adder u_slice (
    .a_i   (nib_a),
    .b_i   (nib_b),
    .cin_i (carry_q),
    .sum_o (nib_sum),
    .cout_o(nib_cout)
  );

  // Carry into bit 3 of the current nibble, recovered from the slice's sum bit.
  assign msb_cin = nib_a[3] ^ nib_b[3] ^ nib_sum[3];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          state_d = StAdd;
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      StAdd: begin
        sum_d[bit_off +: 4] = nib_sum;
        carry_d             = nib_cout;
        idx_d               = idx_q + 1'b1;
        if (idx_q == LastIdx) begin
          state_d = StDone;
          cout_d  = nib_cout;
          ovf_d   = msb_cin ^ nib_cout;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q == StAdd);
  assign out_valid = (state_q == StDone);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;

endmodule
